// File: rtl/uart_mmio_pkg.sv
// uart_mmio shared definitions: register offsets,
// CON bit positions and serial FSM state encodings.
package uart_pkg;

  localparam logic [3:0] OFF_TXD = 4'h0;
  localparam logic [3:0] OFF_RXD = 4'h4;
  localparam logic [3:0] OFF_CON = 4'h8;

  localparam int CON_BUSY  = 0;
  localparam int CON_DONE  = 1;
  localparam int CON_VALID = 2;
  localparam int CON_OVR   = 3;
  localparam int CON_FERR  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } ser_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// MEM-stage device bus as seen by uart_mmio.
// The CPU side is master, the UART is slave.
interface uart_mmio_if;

  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        MemRead;
  logic        MemWrite;

  modport master (
    output Address,
    output Write_data,
    output MemRead,
    output MemWrite,
    input  Read_data
  );

  modport slave (
    input  Address,
    input  Write_data,
    input  MemRead,
    input  MemWrite,
    output Read_data
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer plus sampling FSM.
// Emits a one-cycle strobe per good byte or framing error.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          s1;
  logic          s2;
  logic          s2_d;
  ser_state_t    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic          brk;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      s2_d      <= 1'b1;
      st        <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      brk       <= 1'b0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      s1        <= rx;
      s2        <= s1;
      s2_d      <= s2;
      rx_strobe <= 1'b0;
      rx_ferr   <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (s2_d && !s2) begin
            st  <= S_START;
            cnt <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= s2 ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL) begin
            cnt <= '0;
            sh  <= {s2, sh[7:1]};
            if (bit_idx == 3'd7) st <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          // after a bad stop bit, hold until the line idles high
          if (brk) begin
            if (s2) begin
              brk <= 1'b0;
              st  <= S_IDLE;
            end
          end else if (cnt == FULL) begin
            cnt <= '0;
            if (s2) begin
              rx_byte   <= sh;
              rx_strobe <= 1'b1;
              st        <= S_IDLE;
            end else begin
              rx_ferr <= 1'b1;
              brk     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: TXD/RXD/CON registers,
// 8N1 transmitter and an instance of uart_rx_core.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic  clk,
  input  logic  reset,
  uart_mmio_if.slave bus,
  input  logic  uart_rx,
  output logic  uart_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] A_TXD = BASE_ADDR + 32'(OFF_TXD);
  localparam logic [31:0] A_RXD = BASE_ADDR + 32'(OFF_RXD);
  localparam logic [31:0] A_CON = BASE_ADDR + 32'(OFF_CON);

  logic hit_txd;
  logic hit_rxd;
  logic hit_con;
  logic wr_txd;
  logic wr_con;
  logic rd_rxd;

  assign hit_txd = bus.Address[31:2] == A_TXD[31:2];
  assign hit_rxd = bus.Address[31:2] == A_RXD[31:2];
  assign hit_con = bus.Address[31:2] == A_CON[31:2];
  assign wr_txd  = bus.MemWrite && hit_txd;
  assign wr_con  = bus.MemWrite && hit_con;
  assign rd_rxd  = bus.MemRead  && hit_rxd;

  logic unused_bits;
  assign unused_bits = ^{bus.Write_data[31:8],
                         bus.Address[1:0]};

  ser_state_t    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic [7:0]    last_tx_byte;
  logic          tx_last;
  logic          tx_fin;
  logic          tx_busy;

  assign tx_last = tx_cnt == FULL;
  assign tx_fin  = (tx_state == S_STOP) && tx_last;
  assign tx_busy = tx_state != S_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state     <= S_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_sh        <= '0;
      last_tx_byte <= '0;
      uart_tx      <= 1'b1;
    end else begin
      unique case (tx_state)
        S_IDLE: begin
          if (wr_txd) begin
            tx_state     <= S_START;
            tx_sh        <= bus.Write_data[7:0];
            last_tx_byte <= bus.Write_data[7:0];
            tx_cnt       <= '0;
            uart_tx      <= 1'b0;
          end
        end
        S_START: begin
          if (tx_last) begin
            tx_state <= S_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_last) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_ferr   (rx_ferr)
  );

  logic       tx_done;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic [7:0] rx_data;
  logic       clr_done;
  logic       clr_ovr;
  logic       clr_ferr;

  assign clr_done = wr_con && bus.Write_data[CON_DONE];
  assign clr_ovr  = wr_con && bus.Write_data[CON_OVR];
  assign clr_ferr = wr_con && bus.Write_data[CON_FERR];

  // set terms win over same-edge clears and reads
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_done    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rx_data    <= '0;
    end else begin
      tx_done    <= tx_fin | (tx_done & ~clr_done);
      rx_valid   <= rx_strobe | (rx_valid & ~rd_rxd);
      rx_overrun <= (rx_strobe & rx_valid)
                  | (rx_overrun & ~clr_ovr);
      frame_err  <= rx_ferr | (frame_err & ~clr_ferr);
      if (rx_strobe) rx_data <= rx_byte;
    end
  end

  always_comb begin
    bus.Read_data = '0;
    if (bus.MemRead) begin
      unique case (1'b1)
        hit_txd: bus.Read_data = {24'b0, last_tx_byte};
        hit_rxd: bus.Read_data = {24'b0, rx_data};
        hit_con: bus.Read_data = {27'b0, frame_err,
                                  rx_overrun, rx_valid,
                                  tx_done, tx_busy};
        default: bus.Read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized self-checking bench for uart_mmio
// against a frame-level model of the register map.
module tb_uart_mmio;

  localparam int C = 4;
  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = TXD + 32'd4;
  localparam logic [31:0] CON = TXD + 32'd8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;

  uart_mmio_if bus ();

  uart_mmio #(
    .CLKS_PER_BIT (C),
    .BASE_ADDR    (TXD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_last;
  logic [7:0] m_rx;
  logic       m_valid;
  logic       m_ovr;
  logic       m_ferr;
  logic       m_done;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] con_exp(input logic busy);
    return {27'b0, m_ferr, m_ovr, m_valid, m_done, busy};
  endfunction

  task automatic model_reset();
    m_last  = '0;
    m_rx    = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus.Address    = a;
    bus.Write_data = d;
    bus.MemWrite   = 1'b1;
    bus.MemRead    = 1'b0;
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    bus.Address  = a;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    #1 check(tag, bus.Read_data, exp);
    @(negedge clk);
    bus.MemRead = 1'b0;
  endtask

  // write b, then follow the line bit by bit; a second
  // TXD write is slipped in at frame offset inj (if >= 0)
  task automatic tx_frame(input logic [7:0] b,
                          input int inj);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    wr(TXD, {24'h0, b});
    m_last = b;
    for (int k = 0; k < 10 * C; k++) begin
      if (k == inj) begin
        bus.Address    = TXD;
        bus.Write_data = 32'hFF;
        bus.MemWrite   = 1'b1;
        bus.MemRead    = 1'b0;
      end else begin
        bus.Address  = CON;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
      end
      #1;
      check("tx_line", {31'b0, uart_tx},
            {31'b0, fr[k / C]});
      if (k != inj)
        check("tx_busy", {31'b0, bus.Read_data[0]}, 32'd1);
      @(negedge clk);
    end
    bus.MemWrite = 1'b0;
    m_done = 1'b1;
    bus.Address = CON;
    bus.MemRead = 1'b1;
    #1;
    check("tx_idle_line", {31'b0, uart_tx}, 32'd1);
    check("tx_idle_con", bus.Read_data, con_exp(1'b0));
    bus.MemRead = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b,
                         input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (C) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_rx    = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bus.Address    = '0;
    bus.Write_data = '0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    rd_chk("rst_con", CON, 32'd0);
    rd_chk("unmapped", 32'h4000_0010, 32'd0);
    rd_chk("rst_txd", TXD, 32'd0);
    rd_chk("rst_rxd", RXD, 32'd0);

    tx_frame(8'h55, -1);
    @(negedge clk);
    rd_chk("con_done", CON, 32'h2);
    rd_chk("txd_55", TXD, {24'b0, m_last});
    bus.Address = TXD;
    bus.MemRead = 1'b0;
    #1 check("no_strobe", bus.Read_data, 32'd0);
    @(negedge clk);
    wr(CON, 32'h2);
    m_done = 1'b0;
    rd_chk("con_clr_done", CON, con_exp(1'b0));

    tx_frame(8'hA3, 9);
    @(negedge clk);
    rd_chk("txd_kept", TXD, 32'hA3);

    // back-to-back frames, each written in the first idle cycle
    for (int i = 0; i < 3; i++) begin
      tx_frame(8'($urandom), -1);
    end
    @(negedge clk);
    rd_chk("txd_rand", TXD, {24'b0, m_last});

    send_rx(8'h3C, 1'b1);
    rd_chk("rx_con", CON, con_exp(1'b0));
    rd_chk("rxd_3c", RXD, {24'b0, m_rx});
    m_valid = 1'b0;
    rd_chk("rx_con_clr", CON, con_exp(1'b0));

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_chk("ovr_con", CON, con_exp(1'b0));
    wr(CON, 32'h8);
    m_ovr = 1'b0;
    rd_chk("ovr_clr", CON, con_exp(1'b0));
    rd_chk("rxd_22", RXD, {24'b0, m_rx});
    m_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      rd_chk("rxd_rand", RXD, {24'b0, m_rx});
      m_valid = 1'b0;
      rd_chk("rx_rand_con", CON, con_exp(1'b0));
    end

    send_rx(8'h5A, 1'b0);
    rd_chk("ferr_con", CON, con_exp(1'b0));
    rd_chk("ferr_rxd", RXD, {24'b0, m_rx});
    wr(CON, 32'h10);
    m_ferr = 1'b0;
    rd_chk("ferr_clr", CON, con_exp(1'b0));

    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * C) @(negedge clk);
    rd_chk("glitch_con", CON, con_exp(1'b0));
    send_rx(8'hC5, 1'b1);
    rd_chk("post_glitch", RXD, {24'b0, m_rx});
    m_valid = 1'b0;

    wr(TXD, 32'h0F);
    m_last = 8'h0F;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
    rd_chk("rst_mid_con", CON, con_exp(1'b0));
    reset = 1'b0;
    @(negedge clk);
    rd_chk("rst_mid_txd", TXD, 32'd0);
    rd_chk("rst_mid_rxd", RXD, 32'd0);
    tx_frame(8'($urandom), -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART responder on the CPU's device bus. It sits beside the existing device controller in the MEM stage and decodes its own word addresses in the device region (`Address[30]=1`). Stores to its registers start serial transmission. Loads return received bytes and status. It contains an independent 8N1 transmitter and receiver, each driven by a bit-period counter.

## Interface
- `CLKS_PER_BIT`, 868 — clock cycles per serial bit (100 MHz / 115200); must be ≥ 4 and even.
- `BASE_ADDR`, 32'h4000_0018 — address of the TXD register; RXD = BASE+4, CON = BASE+8.
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `Address`  in  32  — MEM-stage byte address; match on full word address (bits [1:0] ignored).
- `Write_data`  in  32  — store data; only [7:0] used for TXD, [4:0] for CON.
- `MemRead`  in  1  — load strobe, one cycle per access.
- `MemWrite`  in  1  — store strobe, one cycle per access.
- `Read_data`  out  32  — combinational read data; 0 when no register matches or `MemRead`=0.
- `uart_rx`  in  1  — asynchronous serial input, idle high.
- `uart_tx`  out  1  — registered serial output, idle high.

## Operation
- Register map:
  - TXD: write loads the byte and starts a frame. Read returns `{24'b0, last_tx_byte}`.
  - RXD: read returns `{24'b0, rx_data}` and clears `rx_valid` at that edge.
  - CON: read returns `{27'b0, frame_err, rx_overrun, rx_valid, tx_done, tx_busy}`. Write with bit1/3/4 set clears `tx_done`/`rx_overrun`/`frame_err`. Other bits are ignored.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - A TXD write in IDLE captures the byte and enters START.
  - Each state holds its line value for `CLKS_PER_BIT` cycles.
  - DATA shifts 8 bits LSB first.
  - Leaving STOP sets `tx_done`.
  - A TXD write while busy is dropped; `last_tx_byte` is unchanged.
- RX path: `uart_rx` passes through a 2-flop synchronizer, then the RX FSM IDLE → START → DATA → STOP.
  - IDLE: a synchronized high→low transition enters START.
  - START: samples at `CLKS_PER_BIT/2`. If the line is high again, return to IDLE (glitch); otherwise go to DATA.
  - DATA: samples every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - STOP: samples mid-bit. If high, load `rx_data` and set `rx_valid`; if `rx_valid` was already set, also set `rx_overrun` (the new byte overwrites). If low, discard the byte, set `frame_err`, and wait for the line to go high before returning to IDLE.
- Simultaneous events:
  - An RXD read on the same edge a byte completes leaves `rx_valid`=1 and the new byte stored.
  - A CON clear on the same edge a flag sets leaves the flag set.
- Reset: `uart_tx`=1, both FSMs IDLE, counters 0, all flags 0, `rx_data`=0, `last_tx_byte`=0. Reset mid-frame aborts immediately; the line returns high the next cycle.

## Timing
- Write latency: `uart_tx` falls in the cycle after the TXD-write edge.
- Frame timing:
  - The frame lasts exactly `10*CLKS_PER_BIT` cycles.
  - `tx_busy` is high from the cycle after the write through the last stop-bit cycle.
  - `tx_done` is set on the same edge `tx_busy` falls.
- Reads: `Read_data` is purely combinational from `Address`/`MemRead` and current state. Read side effects occur at the edge ending the load cycle.
- RX latency: `rx_valid` rises 2 (synchronizer) + ~`9.5*CLKS_PER_BIT` cycles after the start-bit falling edge.
- Back-to-back frames: TX accepts a new TXD write in the first IDLE cycle after STOP. RX re-arms in IDLE immediately after a good stop sample.

## Structure
- Shared package `uart_pkg`:
  - register offsets (TXD=0, RXD=4, CON=8)
  - CON bit indices
  - TX/RX state encodings (2-bit localparams)
- One sub-module `uart_rx_core`: synchronizer + RX FSM, outputs `rx_byte`, `rx_strobe`, `rx_ferr`. TX and the register file stay in `uart_mmio`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
1. Reset, then idle: `uart_tx`=1; CON reads 0; an unmapped address (0x4000_0010) reads 0.
2. Write TXD=0x55 → `uart_tx` pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. CON bit0=1 for 40 cycles, then CON=0x2. Write CON=0x2 → CON=0.
3. Write TXD=0xA3, then write 0xFF at cycle 10 → the second write is ignored; the frame carries 0xA3; TXD reads 0xA3.
4. Drive RX frame 0x3C → after the stop sample CON bit2=1 and RXD reads 0x3C; the next CON read shows bit2=0.
5. Two RX frames 0x11, 0x22 with no RXD read → RXD=0x22, CON bits2 and 3 set; write CON=0x8 clears the overrun.
6. RX frame with stop bit 0 → `rx_valid` stays 0 and CON bit4=1. Also: a 1-cycle low glitch returns RX to IDLE with no flags; reset asserted mid-TX frame → `uart_tx`=1 the next cycle and CON=0.
